// File: rtl/counter_pkg.sv
// Shared definitions for the up/down counter library.
// Implementation-selector constants and the down-counter run-state encoding.
package counter_pkg;

    // Decrement/increment datapath selector, shared with the up-counter.
    typedef int impl_sel_t;

    localparam impl_sel_t IMPL_CARRY = 0;
    localparam impl_sel_t IMPL_MUX   = 1;

    // Down-counter control state: idle (stopped) or armed/running.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } run_state_t;

endpackage

// File: rtl/counter_down_reload_if.sv
// Control/status bundle of the reloadable down-counter.
// master drives ena/ld/ld_val/stp/arl/prd; slave returns cnt/run/zro/tc.
interface counter_down_reload_if #(
    parameter int WIDTH = 16
);

    logic             ena;
    logic             ld;
    logic [WIDTH-1:0] ld_val;
    logic             stp;
    logic             arl;
    logic [WIDTH-1:0] prd;
    logic [WIDTH-1:0] cnt;
    logic             run;
    logic             zro;
    logic             tc;

    modport master (
        output ena, ld, ld_val, stp, arl, prd,
        input  cnt, run, zro, tc
    );

    modport slave (
        input  ena, ld, ld_val, stp, arl, prd,
        output cnt, run, zro, tc
    );

endinterface

// File: rtl/counter_down_reload_decrementer.sv
// Combinational WIDTH-bit o_res = i_cnt - i_dec, structure chosen by IMPLEMENTATION.
// Ports: i_cnt (operand), i_dec (decrement request), o_res (result).
module counter_down_reload_decrementer
    import counter_pkg::*;
#(
    parameter int        WIDTH          = 16,
    parameter impl_sel_t IMPLEMENTATION = IMPL_CARRY
) (
    input  logic [WIDTH-1:0] i_cnt,
    input  logic             i_dec,
    output logic [WIDTH-1:0] o_res
);

    generate
        case (IMPLEMENTATION)
            IMPL_CARRY: begin : g_carry
                // dec folded in as the borrow of a single subtractor
                assign o_res = i_cnt - WIDTH'(i_dec);
            end
            IMPL_MUX: begin : g_mux
                // constant decrementer followed by a select
                logic [WIDTH-1:0] w_minus1;
                assign w_minus1 = i_cnt - WIDTH'(1);
                assign o_res    = i_dec ? w_minus1 : i_cnt;
            end
            default: begin : g_bad
                assign o_res = i_cnt;
                $fatal(1, "counter_down_reload: unsupported IMPLEMENTATION");
            end
        endcase
    endgenerate

endmodule

// File: rtl/counter_down_reload.sv
// Loadable down-counter with terminal-count pulse and optional auto-reload.
// Ports: clk, rst (async, active-high), bus (slave: ena/ld/ld_val/stp/arl/prd in; cnt/run/zro/tc out).
module counter_down_reload
    import counter_pkg::*;
#(
    parameter int        WIDTH          = 16,
    parameter impl_sel_t IMPLEMENTATION = IMPL_CARRY
) (
    input  logic                  clk,
    input  logic                  rst,
    counter_down_reload_if.slave  bus
);

    run_state_t       r_state;
    logic [WIDTH-1:0] r_cnt;
    logic             r_tc;

    logic             w_run;
    logic             w_zero;
    logic             w_dec;
    logic [WIDTH-1:0] w_cnt_dec;

    assign w_run  = (r_state == ST_RUN);
    assign w_zero = (r_cnt == '0);
    assign w_dec  = w_run & bus.ena & ~bus.ld & ~bus.stp;

    // Gated at zero so the datapath itself can never underflow.
    counter_down_reload_decrementer #(
        .WIDTH          (WIDTH),
        .IMPLEMENTATION (IMPLEMENTATION)
    ) u_dec (
        .i_cnt (r_cnt),
        .i_dec (w_dec & ~w_zero),
        .o_res (w_cnt_dec)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_tc    <= 1'b0;
        end else begin
            r_tc <= 1'b0;
            if (bus.ld) begin
                r_cnt   <= bus.ld_val;
                r_state <= bus.stp ? ST_IDLE : ST_RUN;
            end else if (bus.stp) begin
                r_state <= ST_IDLE;
            end else if (w_dec) begin
                if (w_zero) begin
                    // terminal count: reload or fall idle at zero
                    r_tc <= 1'b1;
                    if (bus.arl) begin
                        r_cnt <= bus.prd;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end else begin
                    r_cnt <= w_cnt_dec;
                end
            end
        end
    end

    assign bus.cnt = r_cnt;
    assign bus.run = w_run;
    assign bus.tc  = r_tc;
    assign bus.zro = w_zero;

endmodule

// File: tb/tb_counter_down_reload.sv
// Directed bench for counter_down_reload, both datapath implementations.
// Table-driven cycle vectors plus hand-written reset and full-range sequences.
module tb_counter_down_reload;
    import counter_pkg::*;

    localparam int W = 4;

    logic clk;
    logic rst;

    counter_down_reload_if #(.WIDTH(W)) if0 ();
    counter_down_reload_if #(.WIDTH(W)) if1 ();

    assign if1.ena    = if0.ena;
    assign if1.ld     = if0.ld;
    assign if1.ld_val = if0.ld_val;
    assign if1.stp    = if0.stp;
    assign if1.arl    = if0.arl;
    assign if1.prd    = if0.prd;

    counter_down_reload #(.WIDTH(W), .IMPLEMENTATION(IMPL_CARRY)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    counter_down_reload #(.WIDTH(W), .IMPLEMENTATION(IMPL_MUX)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        logic       ena;
        logic       ld;
        logic [3:0] ldv;
        logic       stp;
        logic       arl;
        logic [3:0] prd;
        logic [3:0] cnt;
        logic       run;
        logic       tc;
        logic       zro;
    } vec_t;

    vec_t vq[$];
    int   n_chk = 0;
    int   n_err = 0;

    function automatic vec_t mk(
        input string nm, input logic ena, input logic ld,
        input logic [3:0] ldv, input logic stp, input logic arl,
        input logic [3:0] prd, input logic [3:0] cnt,
        input logic run, input logic tc, input logic zro
    );
        vec_t v;
        v.nm = nm; v.ena = ena; v.ld = ld; v.ldv = ldv;
        v.stp = stp; v.arl = arl; v.prd = prd;
        v.cnt = cnt; v.run = run; v.tc = tc; v.zro = zro;
        return v;
    endfunction

    task automatic chk1(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic [3:0] cnt,
                           input logic run, input logic tc, input logic zro);
        chk1({nm, " d0.cnt"}, if0.cnt, cnt);
        chk1({nm, " d0.run"}, {3'b0, if0.run}, {3'b0, run});
        chk1({nm, " d0.tc"},  {3'b0, if0.tc},  {3'b0, tc});
        chk1({nm, " d0.zro"}, {3'b0, if0.zro}, {3'b0, zro});
        chk1({nm, " d1.cnt"}, if1.cnt, cnt);
        chk1({nm, " d1.run"}, {3'b0, if1.run}, {3'b0, run});
        chk1({nm, " d1.tc"},  {3'b0, if1.tc},  {3'b0, tc});
        chk1({nm, " d1.zro"}, {3'b0, if1.zro}, {3'b0, zro});
    endtask

    task automatic drive(input logic ena, input logic ld, input logic [3:0] ldv,
                         input logic stp, input logic arl, input logic [3:0] prd);
        if0.ena = ena; if0.ld = ld; if0.ld_val = ldv;
        if0.stp = stp; if0.arl = arl; if0.prd = prd;
    endtask

    task automatic step_chk(input string nm, input logic [3:0] cnt,
                            input logic run, input logic tc, input logic zro);
        @(posedge clk);
        #1;
        chk_all(nm, cnt, run, tc, zro);
    endtask

    initial begin
        //            name      ena ld ldv  stp arl prd   cnt  run tc zro
        vq.push_back(mk("os_ld",  0, 1, 4'd3, 0, 0, 4'd0, 4'd3, 1, 0, 0));
        vq.push_back(mk("os_d1",  1, 0, 4'd0, 0, 0, 4'd0, 4'd2, 1, 0, 0));
        vq.push_back(mk("os_d2",  1, 0, 4'd0, 0, 0, 4'd0, 4'd1, 1, 0, 0));
        vq.push_back(mk("os_d3",  1, 0, 4'd0, 0, 0, 4'd0, 4'd0, 1, 0, 1));
        vq.push_back(mk("os_tc",  1, 0, 4'd0, 0, 0, 4'd0, 4'd0, 0, 1, 1));
        vq.push_back(mk("os_hld", 1, 0, 4'd0, 0, 0, 4'd0, 4'd0, 0, 0, 1));
        vq.push_back(mk("ar_ld",  0, 1, 4'd2, 0, 1, 4'd4, 4'd2, 1, 0, 0));
        vq.push_back(mk("ar_d1",  1, 0, 4'd0, 0, 1, 4'd4, 4'd1, 1, 0, 0));
        vq.push_back(mk("ar_d2",  1, 0, 4'd0, 0, 1, 4'd4, 4'd0, 1, 0, 1));
        vq.push_back(mk("ar_tc1", 1, 0, 4'd0, 0, 1, 4'd4, 4'd4, 1, 1, 0));
        vq.push_back(mk("ar_d3",  1, 0, 4'd0, 0, 1, 4'd4, 4'd3, 1, 0, 0));
        vq.push_back(mk("ar_d4",  1, 0, 4'd0, 0, 1, 4'd4, 4'd2, 1, 0, 0));
        vq.push_back(mk("ar_d5",  1, 0, 4'd0, 0, 1, 4'd4, 4'd1, 1, 0, 0));
        vq.push_back(mk("ar_d6",  1, 0, 4'd0, 0, 1, 4'd4, 4'd0, 1, 0, 1));
        vq.push_back(mk("ar_tc2", 1, 0, 4'd0, 0, 1, 4'd4, 4'd4, 1, 1, 0));
        vq.push_back(mk("gp_ld",  0, 1, 4'd2, 0, 0, 4'd0, 4'd2, 1, 0, 0));
        vq.push_back(mk("gp_e1",  1, 0, 4'd0, 0, 0, 4'd0, 4'd1, 1, 0, 0));
        vq.push_back(mk("gp_g1",  0, 0, 4'd0, 0, 0, 4'd0, 4'd1, 1, 0, 0));
        vq.push_back(mk("gp_e2",  1, 0, 4'd0, 0, 0, 4'd0, 4'd0, 1, 0, 1));
        vq.push_back(mk("gp_g2",  0, 0, 4'd0, 0, 0, 4'd0, 4'd0, 1, 0, 1));
        vq.push_back(mk("gp_e3",  1, 0, 4'd0, 0, 0, 4'd0, 4'd0, 0, 1, 1));
        vq.push_back(mk("ldstp",  0, 1, 4'd7, 1, 0, 4'd0, 4'd7, 0, 0, 0));
        vq.push_back(mk("stp_en", 1, 0, 4'd0, 0, 0, 4'd0, 4'd7, 0, 0, 0));
        vq.push_back(mk("tl_ld0", 0, 1, 4'd0, 0, 1, 4'd4, 4'd0, 1, 0, 1));
        vq.push_back(mk("tl_ld9", 1, 1, 4'd9, 0, 1, 4'd4, 4'd9, 1, 0, 0));
        vq.push_back(mk("sz_ld0", 0, 1, 4'd0, 0, 0, 4'd0, 4'd0, 1, 0, 1));
        vq.push_back(mk("sz_stp", 1, 0, 4'd0, 1, 0, 4'd0, 4'd0, 0, 0, 1));
        vq.push_back(mk("p0_ld",  0, 1, 4'd1, 0, 1, 4'd0, 4'd1, 1, 0, 0));
        vq.push_back(mk("p0_d",   1, 0, 4'd0, 0, 1, 4'd0, 4'd0, 1, 0, 1));
        vq.push_back(mk("p0_tc1", 1, 0, 4'd0, 0, 1, 4'd0, 4'd0, 1, 1, 1));
        vq.push_back(mk("p0_tc2", 1, 0, 4'd0, 0, 1, 4'd0, 4'd0, 1, 1, 1));
        vq.push_back(mk("p0_tc3", 1, 0, 4'd0, 0, 1, 4'd0, 4'd0, 1, 1, 1));
        vq.push_back(mk("p0_off", 0, 0, 4'd0, 0, 1, 4'd0, 4'd0, 1, 0, 1));
        vq.push_back(mk("pc_ld",  0, 1, 4'd1, 0, 1, 4'd3, 4'd1, 1, 0, 0));
        vq.push_back(mk("pc_d",   1, 0, 4'd0, 0, 1, 4'd5, 4'd0, 1, 0, 1));
        vq.push_back(mk("pc_tc",  1, 0, 4'd0, 0, 1, 4'd5, 4'd5, 1, 1, 0));

        rst = 1'b1;
        drive(0, 0, 4'd0, 0, 0, 4'd0);
        #12;
        chk_all("reset", 4'd0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        #1;

        foreach (vq[i]) begin
            drive(vq[i].ena, vq[i].ld, vq[i].ldv, vq[i].stp, vq[i].arl, vq[i].prd);
            step_chk(vq[i].nm, vq[i].cnt, vq[i].run, vq[i].tc, vq[i].zro);
        end

        // full-range one-shot: 15 down to 0 then tc, never wrapping
        drive(0, 1, 4'hF, 0, 0, 4'd0);
        step_chk("fr_ld", 4'hF, 1'b1, 1'b0, 1'b0);
        drive(1, 0, 4'd0, 0, 0, 4'd0);
        for (int k = 14; k >= 0; k--) begin
            step_chk("fr_dec", 4'(k), 1'b1, 1'b0, (k == 0));
        end
        step_chk("fr_tc", 4'd0, 1'b0, 1'b1, 1'b1);
        step_chk("fr_nowrap", 4'd0, 1'b0, 1'b0, 1'b1);

        // asynchronous reset mid-cycle while running at 5
        drive(0, 1, 4'd5, 0, 0, 4'd0);
        step_chk("ar5_ld", 4'd5, 1'b1, 1'b0, 1'b0);
        drive(1, 0, 4'd0, 0, 0, 4'd0);
        #3;
        rst = 1'b1;
        #1;
        chk_all("arst_now", 4'd0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step_chk("arst_hold", 4'd0, 1'b0, 1'b0, 1'b1);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(1, 0, 4'd0, 0, 0, 4'd0);
        step_chk("arst_idle", 4'd0, 1'b0, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
